pc_gen: RTL and testbench

Registered program-counter generator for the Core101 fetch stage. It selects the next fetch address from correction, return-address-stack, prediction, or sequential sources, and holds it in a PC register. It also maintains a parametrised return address stack (RAS) so predicted calls and returns are handled without the branch predictor. It sits between the branch predictor/execute redirect logic and the instruction memory address port.

---
 rtl/pc_gen_pkg.sv | 20 ++
 rtl/pc_gen_ras_stack.sv | 75 +++++++
 rtl/pc_gen.sv | 108 ++++++++++
 tb/tb_pc_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the Core101 fetch-stage PC generator.
// Holds next-PC source encodings and default reset/increment values.
package pc_gen_defs;

    typedef enum logic [1:0] {
        SRC_SEQ  = 2'd0,
        SRC_PRED = 2'd1,
        SRC_RAS  = 2'd2,
        SRC_CORR = 2'd3
    } pc_src_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam int          DEF_INC          = 4;

    // Sources that count as a predicted (non-architectural) fetch
    function automatic logic src_is_pred(input pc_src_e src);
        return (src == SRC_PRED) || (src == SRC_RAS);
    endfunction

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Return address stack: circular buffer with a write pointer and count.
// A push into a full stack overwrites the oldest entry and sets ovf.
module ras_stack
    import pc_gen_defs::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            valid,
    output logic            ovf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top_idx;
    logic [CW-1:0]   count;
    logic            full;
    logic            do_pop;
    logic            do_replace;

    assign top_idx    = ptr - PW'(1);
    assign top_data   = mem[top_idx];
    assign valid      = (count != '0);
    assign full       = (count == FULL_CNT);
    assign do_pop     = pop && valid;
    assign do_replace = push && do_pop;

    // Entry storage: a pop+push pair rewrites the top slot in place
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            if (do_replace) begin
                mem[top_idx] <= push_data;
            end else begin
                mem[ptr] <= push_data;
            end
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (flush) begin
            ptr   <= '0;
            count <= '0;
        end else if (do_replace) begin
            ptr   <= ptr;
            count <= count;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (full) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CW'(1);
            end
        end else if (do_pop) begin
            ptr   <= top_idx;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Registered program-counter generator for the Core101 fetch stage.
// Priority: correction, RAS return, prediction, sequential.
module pc_gen
    import pc_gen_defs::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter int              INC          = DEF_INC,
    parameter int              RAS_DEPTH    = 8
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            pc_gen_stall_in,
    input  logic            pc_gen_correction_en_in,
    input  logic [XLEN-1:0] pc_gen_correction_in,
    input  logic            pc_gen_prediction_en_in,
    input  logic [XLEN-1:0] pc_gen_prediction_in,
    input  logic            pc_gen_call_in,
    input  logic            pc_gen_ret_in,
    output logic [XLEN-1:0] pc_gen_pc_out,
    output logic            pc_gen_pred_out,
    output logic            pc_gen_ras_valid_out,
    output logic            pc_gen_ras_ovf_out
);

    localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

    logic [XLEN-1:0] pc;
    logic            pred;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] next_pc;
    logic            next_pred;
    pc_src_e         src;
    logic            load;
    logic            active;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] ras_top;
    logic            ras_valid;
    logic            ras_ovf;

    assign seq_pc = pc + INC_W;
    assign load   = pc_gen_correction_en_in || !pc_gen_stall_in;
    assign active = !pc_gen_stall_in && !pc_gen_correction_en_in;

    // Pick the next-PC source by fixed priority
    always_comb begin
        src = SRC_SEQ;
        if (pc_gen_correction_en_in) begin
            src = SRC_CORR;
        end else if (pc_gen_ret_in && ras_valid) begin
            src = SRC_RAS;
        end else if (pc_gen_prediction_en_in) begin
            src = SRC_PRED;
        end
    end

    // Next-PC mux and predicted flag
    always_comb begin
        next_pc   = seq_pc;
        next_pred = src_is_pred(src);
        unique case (src)
            SRC_CORR: next_pc = pc_gen_correction_in;
            SRC_RAS:  next_pc = ras_top;
            SRC_PRED: next_pc = pc_gen_prediction_in;
            SRC_SEQ:  next_pc = seq_pc;
            default:  next_pc = seq_pc;
        endcase
    end

    // Call/return requests to the RAS, suppressed by stall or redirect
    always_comb begin
        ras_push = active && pc_gen_call_in;
        ras_pop  = active && pc_gen_ret_in && ras_valid;
    end

    // PC and predicted-flag registers
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pc   <= RESET_VECTOR;
            pred <= 1'b0;
        end else if (load) begin
            pc   <= next_pc;
            pred <= next_pred;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (ras_push),
        .pop       (ras_pop),
        .flush     (pc_gen_correction_en_in),
        .push_data (seq_pc),
        .top_data  (ras_top),
        .valid     (ras_valid),
        .ovf       (ras_ovf)
    );

    assign pc_gen_pc_out        = pc;
    assign pc_gen_pred_out      = pred;
    assign pc_gen_ras_valid_out = ras_valid;
    assign pc_gen_ras_ovf_out   = ras_ovf;

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen with hand-computed expectations.
// Each scenario task drives inputs and checks outputs inline.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        corr_en = 1'b0;
    logic [31:0] corr = '0;
    logic        pred_en = 1'b0;
    logic [31:0] pred_t = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic        pred;
    logic        rvalid;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h100),
        .INC          (4),
        .RAS_DEPTH    (8)
    ) dut (
        .clk_in                  (clk),
        .rst_in                  (rst),
        .pc_gen_stall_in         (stall),
        .pc_gen_correction_en_in (corr_en),
        .pc_gen_correction_in    (corr),
        .pc_gen_prediction_en_in (pred_en),
        .pc_gen_prediction_in    (pred_t),
        .pc_gen_call_in          (call),
        .pc_gen_ret_in           (ret),
        .pc_gen_pc_out           (pc),
        .pc_gen_pred_out         (pred),
        .pc_gen_ras_valid_out    (rvalid),
        .pc_gen_ras_ovf_out      (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; corr_en = 0; pred_en = 0;
        call = 0; ret = 0;
    endtask

    task automatic redirect(input logic [31:0] t);
        idle();
        corr_en = 1; corr = t;
        step();
        idle();
    endtask

    task automatic test_reset();
        rst = 0;
        step();
        checks++;
        if (pc !== 32'h100) begin
            errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h100);
        end
        checks++;
        if (pred !== 1'b0 || rvalid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got %b%b%b exp 000", pred, rvalid, ovf);
        end
        rst = 1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (pc !== 32'h100 + 32'(4 * i) || pred !== 1'b0) begin
                errors++;
                $display("FAIL seq_%0d got %h/%b exp %h/0", i, pc, pred,
                         32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_priority();
        redirect(32'h200);
        pred_en = 1; pred_t = 32'h400;
        corr_en = 1; corr = 32'h800;
        step();
        checks++;
        if (pc !== 32'h800 || pred !== 1'b0) begin
            errors++; $display("FAIL corr_over_pred got %h/%b exp 800/0", pc, pred);
        end
        corr_en = 0;
        step();
        checks++;
        if (pc !== 32'h400 || pred !== 1'b1) begin
            errors++; $display("FAIL pred_only got %h/%b exp 400/1", pc, pred);
        end
        idle();
        step();
        checks++;
        if (pc !== 32'h404 || pred !== 1'b0) begin
            errors++; $display("FAIL pred_clear got %h/%b exp 404/0", pc, pred);
        end
    endtask

    task automatic test_call_ret();
        redirect(32'h1000);
        call = 1; pred_en = 1; pred_t = 32'h3000;
        step();
        idle();
        checks++;
        if (pc !== 32'h3000 || rvalid !== 1'b1) begin
            errors++; $display("FAIL call got %h/%b exp 3000/1", pc, rvalid);
        end
        step();
        ret = 1;
        step();
        idle();
        checks++;
        if (pc !== 32'h1004 || pred !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL ret got %h/%b/%b exp 1004/1/0", pc, pred, rvalid);
        end
    endtask

    task automatic test_overflow();
        redirect(32'h5000);
        for (int i = 0; i < 9; i++) begin
            call = 1; pred_en = 1;
            pred_t = 32'h5000 + 32'(256 * (i + 1));
            step();
            if (i == 7) begin
                checks++;
                if (ovf !== 1'b0) begin
                    errors++; $display("FAIL ovf_at_full got %b exp 0", ovf);
                end
            end
        end
        idle();
        checks++;
        if (pc !== 32'h5900 || ovf !== 1'b1 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %h/%b/%b exp 5900/1/1", pc, ovf, rvalid);
        end
        for (int k = 0; k < 8; k++) begin
            ret = 1;
            step();
            checks++;
            if (pc !== 32'h5000 + 32'(256 * (8 - k)) + 32'h4 || pred !== 1'b1) begin
                errors++;
                $display("FAIL pop_%0d got %h/%b exp %h/1", k, pc, pred,
                         32'h5000 + 32'(256 * (8 - k)) + 32'h4);
            end
        end
        checks++;
        if (rvalid !== 1'b0) begin
            errors++; $display("FAIL ras_drained got %b exp 0", rvalid);
        end
        step();
        idle();
        checks++;
        if (pc !== 32'h5108 || pred !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ret_empty got %h/%b/%b exp 5108/0/1", pc, pred, ovf);
        end
    endtask

    task automatic test_stall();
        redirect(32'h6000);
        call = 1; pred_en = 1; pred_t = 32'h7000;
        step();
        stall = 1; call = 1; ret = 1; pred_en = 1; pred_t = 32'h9000;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (pc !== 32'h7000 || pred !== 1'b1 || rvalid !== 1'b1) begin
                errors++;
                $display("FAIL stall_%0d got %h/%b/%b exp 7000/1/1", i, pc, pred,
                         rvalid);
            end
        end
        idle();
        ret = 1;
        step();
        idle();
        checks++;
        if (pc !== 32'h6004 || rvalid !== 1'b0) begin
            errors++; $display("FAIL stall_ras_kept got %h/%b exp 6004/0", pc, rvalid);
        end
        call = 1; pred_en = 1; pred_t = 32'h7000;
        step();
        stall = 1; call = 1; ret = 1; pred_t = 32'h9000;
        corr_en = 1; corr = 32'h40;
        step();
        idle();
        checks++;
        if (pc !== 32'h40 || rvalid !== 1'b0 || pred !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL stall_corr got %h/%b/%b/%b exp 40/0/0/1", pc, rvalid,
                     pred, ovf);
        end
        ret = 1;
        step();
        idle();
        checks++;
        if (pc !== 32'h44 || pred !== 1'b0) begin
            errors++; $display("FAIL flushed_ret got %h/%b exp 44/0", pc, pred);
        end
    endtask

    task automatic test_back_to_back();
        redirect(32'h8000);
        call = 1; pred_en = 1; pred_t = 32'h8100;
        step();
        call = 1; ret = 1; pred_en = 0;
        step();
        idle();
        checks++;
        if (pc !== 32'h8004 || pred !== 1'b1 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL call_ret got %h/%b/%b exp 8004/1/1", pc, pred, rvalid);
        end
        ret = 1;
        step();
        idle();
        checks++;
        if (pc !== 32'h8104 || rvalid !== 1'b0) begin
            errors++; $display("FAIL replaced_top got %h/%b exp 8104/0", pc, rvalid);
        end
        call = 1; ret = 1;
        step();
        idle();
        checks++;
        if (pc !== 32'h8108 || pred !== 1'b0 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL call_ret_empty got %h/%b/%b exp 8108/0/1", pc, pred,
                     rvalid);
        end
    endtask

    task automatic test_wrap_reset();
        redirect(32'hFFFF_FFFC);
        step();
        checks++;
        if (pc !== 32'h0) begin
            errors++; $display("FAIL wrap got %h exp 00000000", pc);
        end
        stall = 1;
        step();
        rst = 0; corr_en = 1; corr = 32'h40;
        step();
        rst = 1;
        idle();
        checks++;
        if (pc !== 32'h100 || pred !== 1'b0 || rvalid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall got %h/%b/%b/%b exp 100/0/0/0", pc, pred,
                     rvalid, ovf);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_call_ret();
        test_overflow();
        test_stall();
        test_back_to_back();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
